// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage in front of a 16-entry register file.
// Holds one instruction in decode (D) and one issued instruction (E).
// A pending-write scoreboard stalls D until its sources and destination are free.
// The register file read addresses are steered so that E's operands arrive
// one cycle after issue. While execute stalls, they are held on E's fields.
module decode_issue #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic [ADDR_WIDTH-1:0]      rn_a,
    output logic [ADDR_WIDTH-1:0]      rm_a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic                       out_wr,
    input  logic                       wb_valid,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,
    input  logic                       flush,
    output logic                       hazard,
    output logic [(1<<ADDR_WIDTH)-1:0] pending
);
    localparam int NREG = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rn;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rm;
        logic                  use_rn;
        logic                  use_rm;
        logic                  wr_rd;
    } dec_t;

    // Register usage by instruction class; the condition field is ignored,
    // so a conditional instruction is treated as if it always executes.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.rn     = ins[16 +: ADDR_WIDTH];
        d.rd     = ins[12 +: ADDR_WIDTH];
        d.rm     = ins[0 +: ADDR_WIDTH];
        d.use_rn = 1'b0;
        d.use_rm = 1'b0;
        d.wr_rd  = 1'b0;
        case (ins[27:26])
            2'b00: begin
                d.use_rn = 1'b1;
                d.use_rm = !ins[25];
                d.wr_rd  = (ins[24:23] != 2'b10);
            end
            2'b01: begin
                d.use_rn = 1'b1;
                d.use_rm = ins[25];
                d.wr_rd  = ins[20];
            end
            default: ;
        endcase
        return d;
    endfunction

    logic        d_valid;
    logic [31:0] d_instr;
    dec_t        d_dec;
    dec_t        e_dec;
    logic        issue;
    logic        accept;
    logic        e_kill;
    logic [NREG-1:0] pending_nxt;

    assign d_dec = decode(d_instr);
    assign e_dec = decode(out_instr);

    // A write-after-write conflict is blocked as well, so at most one write is in flight per register.
    assign hazard = d_valid && ((d_dec.use_rn && pending[d_dec.rn]) ||
                                (d_dec.use_rm && pending[d_dec.rm]) ||
                                (d_dec.wr_rd  && pending[d_dec.rd]));
    assign issue    = d_valid && !hazard && (!out_valid || out_ready) && !flush;
    assign in_ready = !d_valid || issue;
    assign accept   = in_valid && in_ready && !flush;
    // An unconsumed E killed by flush never reaches writeback, so it releases its reservation here.
    assign e_kill   = flush && out_valid && !out_ready && out_wr;

    // Read addresses track the instruction whose data appears at the next edge.
    assign rn_a = issue ? d_dec.rn : e_dec.rn;
    assign rm_a = issue ? d_dec.rm : e_dec.rm;

    // Next scoreboard state: clear first, then set, so that a set takes priority over a clear.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid)
            pending_nxt[wb_addr] = 1'b0;
        if (e_kill)
            pending_nxt[e_dec.rd] = 1'b0;
        if (issue && d_dec.wr_rd)
            pending_nxt[d_dec.rd] = 1'b1;
    end

    // Decode holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_instr <= in_instr;
        end else if (issue) begin
            d_valid <= 1'b0;
        end
    end

    // Issue holding register: the fields stay in place after consumption so the held addresses remain stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_wr    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wr    <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_instr <= d_instr;
            out_wr    <= d_dec.wr_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pending-write scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed table-driven bench for decode_issue, plus
// hand-written flush and asynchronous-reset sequences.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [3:0]  rn_a;
    logic [3:0]  rm_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_wr;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        flush;
    logic        hazard;
    logic [15:0] pending;

    int n_chk  = 0;
    int n_pass = 0;

    decode_issue #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rn_a(rn_a), .rm_a(rm_a),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_wr(out_wr),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .hazard(hazard), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        ordy;
        logic        wbv;
        logic [3:0]  wba;
        logic        e_ir;
        logic        e_ov;
        logic        e_hz;
        logic [3:0]  e_rn;
        logic [3:0]  e_rm;
        logic [15:0] e_pend;
        logic [31:0] e_oi;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic logic [31:0] alu(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
        return 32'hE000_0000 | (32'(rn) << 16) | (32'(rd) << 12) | 32'(rm);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic set_row(input int i, input logic iv, input logic [31:0] instr, input logic ordy,
                           input logic wbv, input logic [3:0] wba, input logic e_ir, input logic e_ov,
                           input logic e_hz, input logic [3:0] e_rn, input logic [3:0] e_rm,
                           input logic [15:0] e_pend, input logic [31:0] e_oi);
        tbl[i] = '{iv, instr, ordy, wbv, wba, e_ir, e_ov, e_hz, e_rn, e_rm, e_pend, e_oi};
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] A1, A2, A3, A4, C, S1, S2, CMP, STR, BR, NOP, R, R2, W, X;

    initial begin
        A1  = alu(1, 8, 9);   A2 = alu(2, 9, 10);
        A3  = alu(3, 10, 11); A4 = alu(4, 11, 8);
        C   = alu(5, 3, 12);
        S1  = alu(13, 5, 6);  S2 = alu(14, 7, 7);
        CMP = 32'hE100_0000 | (32'd1 << 16) | (32'd9 << 12) | 32'd2;
        STR = 32'hE403_A000;
        BR  = 32'hE800_B000;
        NOP = 32'hEC00_C000;
        R   = alu(15, 9, 10); R2 = alu(0, 11, 12);
        W   = alu(7, 1, 2);   X  = alu(8, 3, 4);

        //          i  iv instr ordy wbv wba    ir ov hz rn  rm  pend      oi
        set_row( 0, 1, A1,  1, 0, 0,   1, 0, 0, 0,  0,  16'h0000, 32'h0);
        set_row( 1, 1, A2,  1, 0, 0,   1, 0, 0, 8,  9,  16'h0000, 32'h0);
        set_row( 2, 1, A3,  1, 0, 0,   1, 1, 0, 9,  10, 16'h0002, A1);
        set_row( 3, 1, A4,  1, 0, 0,   1, 1, 0, 10, 11, 16'h0006, A2);
        set_row( 4, 0, 0,   1, 0, 0,   1, 1, 0, 11, 8,  16'h000E, A3);
        set_row( 5, 0, 0,   1, 0, 0,   1, 1, 0, 11, 8,  16'h001E, A4);
        set_row( 6, 1, C,   1, 0, 0,   1, 0, 0, 11, 8,  16'h001E, A4);
        set_row( 7, 0, 0,   1, 0, 0,   0, 0, 1, 11, 8,  16'h001E, A4);
        set_row( 8, 0, 0,   1, 0, 0,   0, 0, 1, 11, 8,  16'h001E, A4);
        set_row( 9, 0, 0,   1, 1, 3,   0, 0, 1, 11, 8,  16'h001E, A4);
        set_row(10, 0, 0,   1, 0, 0,   1, 0, 0, 3,  12, 16'h0016, A4);
        set_row(11, 1, S1,  1, 1, 5,   1, 1, 0, 3,  12, 16'h0036, C);
        set_row(12, 1, S2,  1, 1, 1,   1, 0, 0, 5,  6,  16'h0016, C);
        set_row(13, 0, 0,   0, 1, 2,   0, 1, 0, 5,  6,  16'h2014, S1);
        set_row(14, 0, 0,   0, 1, 4,   0, 1, 0, 5,  6,  16'h2010, S1);
        set_row(15, 0, 0,   0, 0, 0,   0, 1, 0, 5,  6,  16'h2000, S1);
        set_row(16, 0, 0,   1, 0, 0,   1, 1, 0, 7,  7,  16'h2000, S1);
        set_row(17, 0, 0,   1, 1, 13,  1, 1, 0, 7,  7,  16'h6000, S2);
        set_row(18, 0, 0,   1, 1, 14,  1, 0, 0, 7,  7,  16'h4000, S2);
        set_row(19, 1, CMP, 1, 0, 0,   1, 0, 0, 7,  7,  16'h0000, S2);
        set_row(20, 1, STR, 1, 0, 0,   1, 0, 0, 1,  2,  16'h0000, S2);
        set_row(21, 1, BR,  1, 0, 0,   1, 1, 0, 3,  0,  16'h0000, CMP);
        set_row(22, 1, NOP, 1, 0, 0,   1, 1, 0, 0,  0,  16'h0000, STR);
        set_row(23, 1, R,   1, 0, 0,   1, 1, 0, 0,  0,  16'h0000, BR);
        set_row(24, 1, R2,  1, 0, 0,   1, 1, 0, 9,  10, 16'h0000, NOP);
        set_row(25, 0, 0,   1, 0, 0,   1, 1, 0, 11, 12, 16'h8000, R);
        set_row(26, 0, 0,   1, 0, 0,   1, 1, 0, 11, 12, 16'h8001, R2);

        // Reset values are visible before any clock edge.
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("rst_in_ready",  0, 32'(in_ready),  32'd1);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_hazard",    0, 32'(hazard),    32'd0);
        chk("rst_pending",   0, 32'(pending),   32'd0);
        chk("rst_rn_a",      0, 32'(rn_a),      32'd0);
        chk("rst_rm_a",      0, 32'(rm_a),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: inputs driven after an edge, outputs sampled on the falling edge.
        for (int i = 0; i < NV; i++) begin
            in_valid  = tbl[i].iv;
            in_instr  = tbl[i].instr;
            out_ready = tbl[i].ordy;
            wb_valid  = tbl[i].wbv;
            wb_addr   = tbl[i].wba;
            @(negedge clk);
            chk("in_ready",  i, 32'(in_ready),  32'(tbl[i].e_ir));
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            chk("hazard",    i, 32'(hazard),    32'(tbl[i].e_hz));
            chk("rn_a",      i, 32'(rn_a),      32'(tbl[i].e_rn));
            chk("rm_a",      i, 32'(rm_a),      32'(tbl[i].e_rm));
            chk("pending",   i, 32'(pending),   32'(tbl[i].e_pend));
            chk("out_instr", i, out_instr,      tbl[i].e_oi);
            @(posedge clk); #1;
        end

        // Flush with D and a stalled, writing E (rd=7).
        idle_inputs();
        pulse_reset();
        in_valid = 1'b1; in_instr = W;
        @(posedge clk); #1;
        in_instr = X;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_pending_set", 0, 32'(pending), 32'h0080);
        chk("fl_out_wr",      0, 32'(out_wr),  32'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready_during", 0, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_out_valid",   0, 32'(out_valid), 32'd0);
        chk("fl_pending_clr", 0, 32'(pending),   32'd0);
        chk("fl_in_ready",    0, 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("fl_no_reissue",  0, 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall.
        idle_inputs();
        pulse_reset();
        in_valid = 1'b1; in_instr = W;
        @(posedge clk); #1;
        in_instr = X;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("st_in_ready", 0, 32'(in_ready),  32'd0);
        chk("st_pending",  0, 32'(pending),   32'h0080);
        chk("st_rn_a",     0, 32'(rn_a),      32'd1);
        chk("st_rm_a",     0, 32'(rm_a),      32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 0, 32'(out_valid), 32'd0);
        chk("ar_out_wr",    0, 32'(out_wr),    32'd0);
        chk("ar_out_instr", 0, out_instr,      32'd0);
        chk("ar_pending",   0, 32'(pending),   32'd0);
        chk("ar_rn_a",      0, 32'(rn_a),      32'd0);
        chk("ar_rm_a",      0, 32'(rm_a),      32'd0);
        chk("ar_in_ready",  0, 32'(in_ready),  32'd1);
        chk("ar_hazard",    0, 32'(hazard),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
